// File: rtl/mean_subtract_pkg.sv
// Shared constants for the mean_subtract block: frame geometry, Q1.15 limits,
// FSM state encoding and a small helper for sizing the frame counter.
package mean_pkg;

  // Default frame length (samples per frame, power of two) and sample width.
  localparam int N      = 2048;
  localparam int DATA_W = 16;

  // Q1.15 saturation limits.
  localparam logic [15:0] Q15_MAX = 16'h7FFF;
  localparam logic [15:0] Q15_MIN = 16'h8000;

  // FSM encoding, kept as plain constants so older tools can consume it.
  typedef logic [0:0] state_t;
  localparam state_t WAIT_MEAN = 1'b0;
  localparam state_t RUN       = 1'b1;

  // Width of a counter that indexes 0..n-1. Never returns less than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mean_subtract_if.sv
// Stream bundle for mean_subtract: mean input stream, sample input stream and
// the mean-removed output stream. The block itself connects through 'slave';
// whoever feeds and drains it uses 'master'.
interface mean_subtract_if
  import mean_pkg::*;
#(
  parameter int DATA_W = mean_pkg::DATA_W
);

  // Mean word stream into the block.
  logic              s_axis_mean_tvalid;
  logic              s_axis_mean_tready;
  logic [DATA_W-1:0] mean_in;

  // Sample stream into the block.
  logic              s_axis_data_tvalid;
  logic              s_axis_data_tready;
  logic [DATA_W-1:0] data_in;

  // Mean-removed sample stream out of the block.
  logic              m_axis_data_tvalid;
  logic              m_axis_data_tready;
  logic [DATA_W-1:0] data_out;
  logic              m_axis_data_tlast;

  modport slave (
    input  s_axis_mean_tvalid,
    input  mean_in,
    input  s_axis_data_tvalid,
    input  data_in,
    input  m_axis_data_tready,
    output s_axis_mean_tready,
    output s_axis_data_tready,
    output m_axis_data_tvalid,
    output data_out,
    output m_axis_data_tlast
  );

  modport master (
    output s_axis_mean_tvalid,
    output mean_in,
    output s_axis_data_tvalid,
    output data_in,
    output m_axis_data_tready,
    input  s_axis_mean_tready,
    input  s_axis_data_tready,
    input  m_axis_data_tvalid,
    input  data_out,
    input  m_axis_data_tlast
  );

endinterface

// File: rtl/mean_subtract_sat.sv
// Combinational saturating subtract a - b for W-bit two's complement
// fixed-point values. The difference is formed one bit wider so overflow can
// be seen, then clamped to the most positive / most negative W-bit value
// (0x7FFF / 0x8000 when W is 16).
module sat_sub_q15
  import mean_pkg::*;
#(
  parameter int W = mean_pkg::DATA_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o
);

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W:0] wide;

  // Widen, subtract, and clamp when the top two bits of the result disagree.
  always_comb begin
    wide   = {a_i[W-1], a_i} - {b_i[W-1], b_i};
    diff_o = wide[W-1:0];
    if (wide[W] != wide[W-1]) begin
      diff_o = wide[W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/mean_subtract.sv
// Removes a per-frame mean from a Q1.15 sample stream. After reset the block
// waits for a mean word, then subtracts it (with saturation) from every
// sample, one sample per cycle with one cycle of latency. A mean arriving
// mid-frame is parked in a one-entry pending register and only takes effect
// at the frame boundary, so every frame is processed with a single mean.
module mean_subtract
  import mean_pkg::*;
#(
  parameter int N      = mean_pkg::N,
  parameter int DATA_W = mean_pkg::DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  mean_subtract_if.slave axis
);

  localparam int                CNT_W    = cntWidth(N);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N - 1);

  // Control state.
  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   count_q,     count_d;

  // Mean in use for the current frame and the one queued for the next frame.
  logic [DATA_W-1:0]  meanCur_q,   meanCur_d;
  logic [DATA_W-1:0]  pendMean_q,  pendMean_d;
  logic               pendValid_q, pendValid_d;

  // Output register stage.
  logic [DATA_W-1:0]  dataOut_q,   dataOut_d;
  logic               outValid_q,  outValid_d;
  logic               outLast_q,   outLast_d;

  // Handshake terms.
  logic               meanReady;
  logic               dataReady;
  logic               meanXfer;
  logic               dataXfer;
  logic               frameEnd;
  logic [DATA_W-1:0]  subResult;

  // A mean is always welcome while waiting; in RUN only if the pending slot
  // is free. Samples flow only in RUN and only when the output stage has room.
  assign meanReady = (state_q == WAIT_MEAN) || !pendValid_q;
  assign dataReady = (state_q == RUN) && (!outValid_q || axis.m_axis_data_tready);
  assign meanXfer  = axis.s_axis_mean_tvalid && meanReady;
  assign dataXfer  = axis.s_axis_data_tvalid && dataReady;
  assign frameEnd  = dataXfer && (count_q == LAST_IDX);

  sat_sub_q15 #(
    .W      (DATA_W)
  ) uSatSub (
    .a_i    (axis.data_in),
    .b_i    (meanCur_q),
    .diff_o (subResult)
  );

  // FSM, frame counter and mean bookkeeping.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    meanCur_d   = meanCur_q;
    pendMean_d  = pendMean_q;
    pendValid_d = pendValid_q;

    case (state_q)
      WAIT_MEAN: begin
        if (meanXfer) begin
          meanCur_d   = axis.mean_in;
          count_d     = '0;
          pendValid_d = 1'b0;
          state_d     = RUN;
        end
      end

      RUN: begin
        if (dataXfer) begin
          count_d = count_q + 1'b1;
        end

        // Mean changes land exactly on the frame boundary. The pending slot
        // blocks new means while full, so at most one of the two branches
        // below can have a mean to apply.
        if (frameEnd) begin
          if (pendValid_q) begin
            meanCur_d   = pendMean_q;
            pendValid_d = 1'b0;
          end else if (meanXfer) begin
            meanCur_d = axis.mean_in;
          end
        end else if (meanXfer) begin
          pendMean_d  = axis.mean_in;
          pendValid_d = 1'b1;
        end
      end

      default: begin
        state_d = WAIT_MEAN;
      end
    endcase
  end

  // Output stage: load on accept, hold while stalled, drop valid once drained.
  always_comb begin
    dataOut_d  = dataOut_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;

    if (dataXfer) begin
      dataOut_d  = subResult;
      outLast_d  = frameEnd;
      outValid_d = 1'b1;
    end else if (outValid_q && axis.m_axis_data_tready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers; reset throws away any partial frame and pending mean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT_MEAN;
      count_q     <= '0;
      meanCur_q   <= '0;
      pendMean_q  <= '0;
      pendValid_q <= 1'b0;
      dataOut_q   <= '0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      meanCur_q   <= meanCur_d;
      pendMean_q  <= pendMean_d;
      pendValid_q <= pendValid_d;
      dataOut_q   <= dataOut_d;
      outValid_q  <= outValid_d;
      outLast_q   <= outLast_d;
    end
  end

  assign axis.s_axis_mean_tready = meanReady;
  assign axis.s_axis_data_tready = dataReady;
  assign axis.m_axis_data_tvalid = outValid_q;
  assign axis.data_out           = dataOut_q;
  assign axis.m_axis_data_tlast  = outLast_q;

endmodule

// File: doc/mean_subtract.md
MEAN_SUBTRACT -- requirements
Module: mean_subtract

Interface
REQ-001 Parameter N, default 2048, samples per frame; power of two.
REQ-002 Parameter DATA_W, default 16, sample width, Q1.15 two's complement.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 s_axis_mean_tvalid  input  1  mean word valid.
REQ-006 s_axis_mean_tready  output  1  block can accept a mean word.
REQ-007 mean_in  input  DATA_W  mean value, Q1.15.
REQ-008 s_axis_data_tvalid  input  1  input sample valid.
REQ-009 s_axis_data_tready  output  1  block can accept a sample.
REQ-010 data_in  input  DATA_W  input sample, Q1.15.
REQ-011 m_axis_data_tvalid  output  1  output sample valid.
REQ-012 m_axis_data_tready  input  1  downstream accepts output.
REQ-013 data_out  output  DATA_W  mean-removed sample, Q1.15.
REQ-014 m_axis_data_tlast  output  1  marks last sample (index N-1) of a frame.

Function
REQ-015 A transfer on any port SHALL occur only on a cycle with tvalid and tready both high.
REQ-016 State machine SHALL have two states: WAIT_MEAN (after reset) and RUN.
REQ-017 WAIT_MEAN: s_axis_mean_tready=1, s_axis_data_tready=0; a mean transfer loads mean_cur, clears sample counter and moves to RUN.
REQ-018 RUN: s_axis_data_tready SHALL equal (!m_axis_data_tvalid || m_axis_data_tready).
REQ-019 Each accepted sample SHALL produce data_out = sat(data_in - mean_cur), computed at DATA_W+1 bits and saturated to 0x7FFF / 0x8000.
REQ-020 Latency SHALL be one cycle: output register loaded on the accept edge, m_axis_data_tvalid high from the next cycle.
REQ-021 data_out, tlast and m_axis_data_tvalid SHALL hold stable while tvalid=1 and tready=0.
REQ-022 m_axis_data_tvalid SHALL clear after an output transfer with no new sample accepted the same cycle.
REQ-023 Sample counter log2(N) bits SHALL increment per accepted sample, wrapping N-1 -> 0; tlast=1 for the sample accepted at count N-1.
REQ-024 RUN: one-entry pending-mean register; s_axis_mean_tready = !pending_valid.
REQ-025 A pending mean SHALL be applied to mean_cur only on the cycle the sample with count N-1 is accepted, taking effect from the next frame's first sample.
REQ-026 A mean accepted on the same cycle as the count N-1 sample with pending empty SHALL be applied directly at that boundary.
REQ-027 Without a new mean, mean_cur SHALL be reused for subsequent frames.
REQ-028 Output backpressure SHALL not lose or duplicate samples; throughput one sample per cycle when m_axis_data_tready=1.

Reset
REQ-029 On rst low, immediately: state=WAIT_MEAN, counter=0, mean_cur=0, pending_valid=0, data_out=0, m_axis_data_tvalid=0, m_axis_data_tlast=0.
REQ-030 Reset mid-frame SHALL discard the partial frame and pending mean; operation resumes only after a new mean transfer.

Structure
REQ-031 Shared package mean_pkg SHALL hold N, DATA_W, Q15_MAX=0x7FFF, Q15_MIN=0x8000 and the state encoding.
REQ-032 Saturating subtract SHALL be a combinational sub-module sat_sub_q15.

Verification
REQ-033 Reset, no mean: drive data_in valid -> s_axis_data_tready=0, no output.
REQ-034 mean=0x0100, samples 0x0300,0x0000 -> outputs 0x0200,0xFF00, one cycle latency.
REQ-035 mean=0x8000, sample 0x7FFF -> 0x7FFF (saturated); mean=0x7FFF, sample 0x8000 -> 0x8000.
REQ-036 Mean 0x0010 sent at sample 100, frame mean 0 -> samples 100..N-1 unchanged, next frame offset by 0x0010; tlast on index N-1 only.
REQ-037 Random m_axis_data_tready stalls over 3 frames -> output sequence equals scoreboard, held stable while stalled.
REQ-038 Assert rst at sample 1000 -> all outputs 0 asynchronously, WAIT_MEAN, counter restarts at 0 after next mean.
